// File: rtl/bus_codes_pkg.sv
// Source/destination register codes shared by the bus mux, control unit and
// transfer sequencer.
package bus_codes_pkg;

   localparam int unsigned CODE_W = 5;
   localparam int unsigned NSEL   = 24;

   localparam logic [CODE_W-1:0] SRC_R0     = 5'd0;
   localparam logic [CODE_W-1:0] SRC_R15    = 5'd15;
   localparam logic [CODE_W-1:0] SRC_HI     = 5'd16;
   localparam logic [CODE_W-1:0] SRC_LO     = 5'd17;
   localparam logic [CODE_W-1:0] SRC_ZHI    = 5'd18;
   localparam logic [CODE_W-1:0] SRC_ZLO    = 5'd19;
   localparam logic [CODE_W-1:0] SRC_PC     = 5'd20;
   localparam logic [CODE_W-1:0] SRC_MDR    = 5'd21;
   localparam logic [CODE_W-1:0] SRC_INPORT = 5'd22;
   localparam logic [CODE_W-1:0] SRC_C      = 5'd23;

   localparam logic [CODE_W-1:0] DST_R0      = 5'd0;
   localparam logic [CODE_W-1:0] DST_R15     = 5'd15;
   localparam logic [CODE_W-1:0] DST_HI      = 5'd16;
   localparam logic [CODE_W-1:0] DST_LO      = 5'd17;
   localparam logic [CODE_W-1:0] DST_PC      = 5'd18;
   localparam logic [CODE_W-1:0] DST_MDR     = 5'd19;
   localparam logic [CODE_W-1:0] DST_MAR     = 5'd20;
   localparam logic [CODE_W-1:0] DST_Y       = 5'd21;
   localparam logic [CODE_W-1:0] DST_IR      = 5'd22;
   localparam logic [CODE_W-1:0] DST_OUTPORT = 5'd23;

   typedef struct packed {
      logic [CODE_W-1:0] src;
      logic [CODE_W-1:0] dst;
   } xfer_cmd_t;

   localparam int unsigned CMD_W = $bits(xfer_cmd_t);

   function automatic logic code_legal(input logic [CODE_W-1:0] code, input int unsigned nsel);
      return {1'b0, code} < (CODE_W+1)'(nsel);
   endfunction

endpackage

// File: rtl/xfer_cmd_fifo.sv
// Small synchronous command FIFO; push is ignored when full, pop when empty.
module xfer_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Issues one queued register transfer per cycle as registered one-hot
// source Out / destination In strobes.
module bus_xfer_sequencer
   import bus_codes_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned NSEL  = bus_codes_pkg::NSEL,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CODE_W-1:0] cmd_src,
   input  logic [CODE_W-1:0] cmd_dst,
   input  logic              stall,
   output logic [NSEL-1:0]   src_out,
   output logic [NSEL-1:0]   dst_in,
   output logic              busy,
   output logic              err_illegal,
   output logic [CNT_W-1:0]  xfer_count
);

   localparam logic [NSEL-1:0] ONE = {{(NSEL-1){1'b0}}, 1'b1};

   xfer_cmd_t wr_cmd;
   xfer_cmd_t head;
   logic      full;
   logic      empty;
   logic      legal;
   logic      handshake;
   logic      push;
   logic      pop;

   assign wr_cmd    = '{src: cmd_src, dst: cmd_dst};
   assign legal     = code_legal(cmd_src, NSEL) & code_legal(cmd_dst, NSEL);
   assign cmd_ready = ~full;
   assign handshake = cmd_valid & cmd_ready;
   assign push      = handshake & legal;
   assign pop       = ~stall & ~empty;
   assign busy      = ~empty | (|src_out);

   xfer_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clock   (clock),
      .clear   (clear),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_cmd),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   // Strobes are live for exactly the cycle after the pop edge.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         src_out     <= '0;
         dst_in      <= '0;
         err_illegal <= 1'b0;
         xfer_count  <= '0;
      end else begin
         if (handshake && !legal) err_illegal <= 1'b1;
         if (pop) begin
            src_out    <= ONE << head.src;
            dst_in     <= ONE << head.dst;
            xfer_count <= xfer_count + 1'b1;
         end else begin
            src_out <= '0;
            dst_in  <= '0;
         end
      end
   end

endmodule
